spdif_frame_ctrl: RTL and testbench
===================================

Name: spdif_frame_ctrl

Overview:
- Sequencer downstream of the S/PDIF edge detector.
- Generates the detector's sampling enable from a clock divider.
- Consumes the detector's interval classes (short/long/head) and the shift strobe, recognises B/M/W preambles, and assembles 32-slot subframes.
- Presents the 24-bit sample plus V/U/C, parity status and lock status through a valid/ready output register.

Parameters:
ENA_DIV, 4, i_clk cycles per o_det_ena pulse (1 = o_det_ena constantly high)
LOCK_CNT, 4, consecutive error-free subframes required before o_locked rises

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
o_det_ena  out  1  sampling enable to edge detector
i_sym_stb  in  1  detector shift strobe (level, may be held several cycles)
i_short  in  1  interval class 1 UI (detector "zero")
i_long  in  1  interval class 2 UI (detector "one")
i_head  in  1  interval class 3 UI (detector "head")
o_sample  out  24  audio word, slot 4 = LSB
o_chan  out  1  0 = subframe A (B/M preamble), 1 = subframe B (W)
o_blk_start  out  1  sample came from a B preamble
o_v / o_u / o_c  out  1 each  validity / user / channel-status bits
o_par_err  out  1  even-parity check over slots 4..31 failed
o_valid  out  1  output register holds an unread subframe
i_ready  in  1  consumer accepts when o_valid & i_ready
o_overrun  out  1  one-cycle pulse: unread subframe overwritten
o_sym_err  out  1  one-cycle pulse: illegal interval sequence
o_locked  out  1  stream locked
o_cs  out  40  channel-status bits 0..39, channel A
o_cs_valid  out  1  one-cycle pulse: o_cs updated

Behaviour:
Interface: reset i_rst_n, asynchronous, active-low; clock i_clk.

Reset values:
- All outputs 0, except o_det_ena = 1 when ENA_DIV = 1.
- FSM returns to HUNT.

Enable divider:
- Counter runs 0..ENA_DIV-1.
- o_det_ena is high in the cycle where the count equals 0.

Symbol event:
- An event is the cycle after i_sym_stb rises (registered edge detect).
- Class is taken from i_short/i_long/i_head sampled on that rising edge.
- Zero or more than one class set counts as an illegal interval.

FSM:
- HUNT: head -> PRE (pre_idx = 1). Short/long events are ignored; no error.
- PRE: collects 3 further intervals.
  - 1,1,3 -> B
  - 3,1,1 -> M
  - 2,1,2 -> W
  - Any other sequence -> o_sym_err, HUNT.
  - A legal match -> DATA with slot = 4 and half = 0.
- DATA:
  - Long with half = 0: bit 0.
  - Short with half = 0: set half. Short with half = 1: bit 1, clear half.
  - Long with half = 1: o_sym_err, HUNT.
  - Head: o_sym_err, PRE (pre_idx = 1). This is treated as a new preamble.
  - Bits shift in LSB-first. Slot increments per bit.
  - Completing slot 31 -> COMMIT.
- COMMIT (1 cycle):
  - Load the output register.
  - o_par_err = XOR of slots 4..31.
  - o_blk_start = (preamble == B); o_chan = (preamble == W).
  - Set o_valid. Pulse o_overrun if o_valid & ~i_ready held in that cycle.
  - Go to HUNT.
- Latency: o_valid rises 2 cycles after the event resolving slot 31.

Handshake:
- o_valid clears on o_valid & i_ready unless COMMIT occurs in the same cycle; then it stays set with the new data.

Lock:
- Counter saturates at LOCK_CNT; incremented on COMMIT with o_par_err = 0.
- Cleared on o_sym_err or on a parity error.
- o_locked = (count == LOCK_CNT).

Boundaries:
- Reset mid-subframe discards partial data.
- Preamble sequence check: W or M must follow a completed subframe; B or M must follow W. Otherwise o_sym_err, but the new subframe is still decoded.

Optional Feature:
SPDIF_CHSTAT_EN:
- Defined:
  - A 192-frame counter resets to 0 on a B preamble and increments on each channel-A COMMIT.
  - o_c of channel A for frames 0..39 shifts into o_cs (bit i = frame i).
  - o_cs_valid pulses at COMMIT of frame 39.
  - Any o_sym_err aborts collection until the next B.
- Undefined: o_cs = 0 and o_cs_valid = 0 constantly; no counter logic.

Decomposition:
- Package spdif_pkg:
  - State enum {HUNT, PRE, DATA, COMMIT}.
  - Preamble enum {PRE_B, PRE_M, PRE_W}.
  - Constants SLOT_AUDIO_LO = 4, SLOT_V = 28, SLOT_U = 29, SLOT_C = 30, SLOT_P = 31, FRAMES_PER_BLOCK = 192, CS_BITS = 40.
- Sub-module spdif_ena_gen: the ENA_DIV divider producing o_det_ena.

Test Plan:
- ENA_DIV = 4 after reset -> o_det_ena high every 4th cycle; ENA_DIV = 1 -> constantly high.
- B preamble (3,1,1,3) then sample 0xA5A5A5, V = 0, U = 1, C = 1, even parity -> o_sample = 0xA5A5A5, o_chan = 0, o_blk_start = 1, o_par_err = 0, o_valid 2 cycles after the last event.
- W subframe with parity bit flipped -> o_par_err = 1; lock count cleared; o_locked falls.
- Head event at slot 17 -> o_sym_err pulse; a following 1,1,3 is decoded as B.
- i_ready held 0 across two subframes -> o_overrun pulse; o_sample holds the second word.
- SPDIF_CHSTAT_EN with 40 frames, C pattern 0x12_3456_789A (LSB at frame 0) -> o_cs = 0x123456789A and o_cs_valid pulse at frame 39.

Source files
------------

// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared types and slot constants for the S/PDIF frame sequencer
package spdif_pkg;

  typedef enum logic [1:0] {HUNT, PRE, DATA, COMMIT} state_e;
  typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W} pre_e;

  localparam int SLOT_AUDIO_LO    = 4;
  localparam int SLOT_V           = 28;
  localparam int SLOT_U           = 29;
  localparam int SLOT_C           = 30;
  localparam int SLOT_P           = 31;
  localparam int FRAMES_PER_BLOCK = 192;
  localparam int CS_BITS          = 40;

  // Interval class codes; CLS_BAD covers "no class" and "several classes"
  localparam logic [1:0] CLS_BAD   = 2'd0;
  localparam logic [1:0] CLS_SHORT = 2'd1;
  localparam logic [1:0] CLS_LONG  = 2'd2;
  localparam logic [1:0] CLS_HEAD  = 2'd3;

  function automatic logic [1:0] classify(input logic s, input logic l, input logic h);
    case ({h, l, s})
      3'b001:  return CLS_SHORT;
      3'b010:  return CLS_LONG;
      3'b100:  return CLS_HEAD;
      default: return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/spdif_ena_gen.sv
// rtl/spdif_ena_gen.sv - divider producing the edge-detector sampling enable
module spdif_ena_gen #(
  parameter int ENA_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_det_ena
);

  localparam int CW = (ENA_DIV > 1) ? $clog2(ENA_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ENA_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);

  // Starting at the top of the range keeps the enable low while in reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= CNT_MAX;
    else          cnt_q <= cnt_d;
  end

  assign o_det_ena = (cnt_q == '0);

endmodule

// File: rtl/spdif_frame_ctrl.sv
// rtl/spdif_frame_ctrl.sv - preamble/subframe sequencer with output register and lock
// Optional channel-status capture enabled by SPDIF_CHSTAT_EN.
module spdif_frame_ctrl
  import spdif_pkg::*;
#(
  parameter int ENA_DIV  = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_det_ena,
  input  logic                i_sym_stb,
  input  logic                i_short,
  input  logic                i_long,
  input  logic                i_head,
  output logic [23:0]         o_sample,
  output logic                o_chan,
  output logic                o_blk_start,
  output logic                o_v,
  output logic                o_u,
  output logic                o_c,
  output logic                o_par_err,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_overrun,
  output logic                o_sym_err,
  output logic                o_locked,
  output logic [CS_BITS-1:0]  o_cs,
  output logic                o_cs_valid
);

  localparam int NSLOT = SLOT_P - SLOT_AUDIO_LO + 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);

  spdif_ena_gen #(.ENA_DIV(ENA_DIV)) u_ena (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_det_ena(o_det_ena)
  );

  logic             stb_q, evt_q;
  logic [1:0]       cls_q;
  state_e           state_q, state_d;
  pre_e             pre_q, pre_d, pre_m;
  logic [1:0]       pre_idx_q, pre_idx_d, p1_q, p1_d, p2_q, p2_d;
  logic [4:0]       slot_q, slot_d;
  logic             half_q, half_d, have_last_q, have_last_d, last_w_q, last_w_d;
  logic             sym_err_q, sym_err_d, take_bit, bit_v, pre_ok, seq_bad, commit;
  logic [NSLOT-1:0] sh_q, sh_d;
  logic [LW-1:0]    lock_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stb_q <= 1'b0; evt_q <= 1'b0; cls_q <= CLS_BAD;
    end else begin
      stb_q <= i_sym_stb;
      evt_q <= i_sym_stb & ~stb_q;
      if (i_sym_stb & ~stb_q) cls_q <= classify(i_short, i_long, i_head);
    end
  end

  always_comb begin
    pre_ok = 1'b1;
    pre_m  = PRE_B;
    case ({p1_q, p2_q, cls_q})
      {CLS_SHORT, CLS_SHORT, CLS_HEAD}: pre_m = PRE_B;
      {CLS_HEAD, CLS_SHORT, CLS_SHORT}: pre_m = PRE_M;
      {CLS_LONG, CLS_SHORT, CLS_LONG}:  pre_m = PRE_W;
      default:                          pre_ok = 1'b0;
    endcase
    // Channel A must be followed by W (or M), W must be followed by B or M
    seq_bad = have_last_q & (last_w_q ? (pre_m == PRE_W) : (pre_m == PRE_B));
  end

  assign commit = (state_q == COMMIT);

  always_comb begin
    state_d = state_q; pre_idx_d = pre_idx_q; p1_d = p1_q; p2_d = p2_q; pre_d = pre_q;
    slot_d = slot_q; half_d = half_q; sh_d = sh_q;
    have_last_d = have_last_q; last_w_d = last_w_q;
    sym_err_d = 1'b0; take_bit = 1'b0; bit_v = 1'b0;
    case (state_q)
      HUNT: if (evt_q && cls_q == CLS_HEAD) begin
        state_d = PRE; pre_idx_d = 2'd1;
      end
      PRE: if (evt_q) begin
        if (pre_idx_q == 2'd1) begin
          p1_d = cls_q; pre_idx_d = 2'd2;
        end else if (pre_idx_q == 2'd2) begin
          p2_d = cls_q; pre_idx_d = 2'd3;
        end else if (pre_ok) begin
          pre_d = pre_m; state_d = DATA; slot_d = 5'(SLOT_AUDIO_LO); half_d = 1'b0;
          sym_err_d = seq_bad;
        end else begin
          sym_err_d = 1'b1; state_d = HUNT; have_last_d = 1'b0;
        end
      end
      DATA: if (evt_q) begin
        case (cls_q)
          CLS_LONG: if (half_q) begin
            sym_err_d = 1'b1; state_d = HUNT; have_last_d = 1'b0;
          end else take_bit = 1'b1;
          CLS_SHORT: if (half_q) begin
            take_bit = 1'b1; bit_v = 1'b1; half_d = 1'b0;
          end else half_d = 1'b1;
          CLS_HEAD: begin
            sym_err_d = 1'b1; state_d = PRE; pre_idx_d = 2'd1; have_last_d = 1'b0;
          end
          default: begin
            sym_err_d = 1'b1; state_d = HUNT; have_last_d = 1'b0;
          end
        endcase
        if (take_bit) begin
          sh_d = {bit_v, sh_q[NSLOT-1:1]};
          if (slot_q == 5'(SLOT_P)) state_d = COMMIT;
          else                      slot_d  = slot_q + 5'd1;
        end
      end
      COMMIT: begin
        state_d = HUNT; have_last_d = 1'b1; last_w_d = (pre_q == PRE_W);
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HUNT; pre_idx_q <= 2'd0; p1_q <= CLS_BAD; p2_q <= CLS_BAD; pre_q <= PRE_B;
      slot_q <= '0; half_q <= 1'b0; sh_q <= '0; have_last_q <= 1'b0; last_w_q <= 1'b0;
      sym_err_q <= 1'b0;
    end else begin
      state_q <= state_d; pre_idx_q <= pre_idx_d; p1_q <= p1_d; p2_q <= p2_d; pre_q <= pre_d;
      slot_q <= slot_d; half_q <= half_d; sh_q <= sh_d; have_last_q <= have_last_d;
      last_w_q <= last_w_d; sym_err_q <= sym_err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sample <= '0; o_chan <= 1'b0; o_blk_start <= 1'b0; o_v <= 1'b0; o_u <= 1'b0;
      o_c <= 1'b0; o_par_err <= 1'b0; o_valid <= 1'b0; o_overrun <= 1'b0; lock_q <= '0;
    end else begin
      if (commit) begin
        o_sample    <= sh_q[23:0];
        o_v         <= sh_q[SLOT_V - SLOT_AUDIO_LO];
        o_u         <= sh_q[SLOT_U - SLOT_AUDIO_LO];
        o_c         <= sh_q[SLOT_C - SLOT_AUDIO_LO];
        o_par_err   <= ^sh_q;
        o_blk_start <= (pre_q == PRE_B);
        o_chan      <= (pre_q == PRE_W);
      end
      o_valid   <= commit | (o_valid & ~i_ready);
      o_overrun <= commit & o_valid & ~i_ready;
      if (sym_err_q)                 lock_q <= '0;
      else if (commit && (^sh_q))    lock_q <= '0;
      else if (commit && lock_q != LOCK_MAX) lock_q <= lock_q + LW'(1);
    end
  end

  assign o_sym_err = sym_err_q;
  assign o_locked  = (lock_q == LOCK_MAX);

`ifdef SPDIF_CHSTAT_EN
  logic [7:0]         frm_q, cs_frame;
  logic               cs_act_q, cs_act, cs_take, cs_vld_q;
  logic [CS_BITS-1:0] cs_sh_q, cs_q, cs_next;

  // A B preamble restarts the block at frame 0 and re-arms collection
  always_comb begin
    cs_frame = (pre_q == PRE_B) ? 8'd0 : frm_q;
    cs_act   = cs_act_q | (pre_q == PRE_B);
    cs_take  = commit && (pre_q != PRE_W) && cs_act && (cs_frame < 8'(CS_BITS));
    cs_next  = {sh_q[SLOT_C - SLOT_AUDIO_LO], cs_sh_q[CS_BITS-1:1]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frm_q <= '0; cs_act_q <= 1'b0; cs_sh_q <= '0; cs_q <= '0; cs_vld_q <= 1'b0;
    end else begin
      cs_vld_q <= 1'b0;
      if (sym_err_q) cs_act_q <= 1'b0;
      else if (commit && pre_q != PRE_W) begin
        cs_act_q <= cs_act;
        frm_q    <= (cs_frame == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : cs_frame + 8'd1;
        if (cs_take) begin
          cs_sh_q <= cs_next;
          if (cs_frame == 8'(CS_BITS - 1)) begin
            cs_q <= cs_next; cs_vld_q <= 1'b1;
          end
        end
      end
    end
  end

  assign o_cs       = cs_q;
  assign o_cs_valid = cs_vld_q;
`else
  assign o_cs       = '0;
  assign o_cs_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spdif_frame_ctrl.sv
// tb/tb_spdif_frame_ctrl.sv - randomized directed bench for spdif_frame_ctrl
module tb_spdif_frame_ctrl;
  import spdif_pkg::*;

  localparam int DIV = 4;
  localparam int LCK = 4;

  logic clk = 1'b0, rst_n = 1'b0, stb = 1'b0, i_short = 1'b0, i_long = 1'b0, i_head = 1'b0;
  logic ready = 1'b0;
  logic        o_det_ena, o_chan, o_blk_start, o_v, o_u, o_c, o_par_err, o_valid;
  logic        o_overrun, o_sym_err, o_locked, o_cs_valid;
  logic [23:0] o_sample;
  logic [39:0] o_cs;
  logic        u_det_ena, u_chan, u_blk, u_v, u_u, u_c, u_par, u_valid, u_ovr, u_sym, u_lock, u_csv;
  logic [23:0] u_sample;
  logic [39:0] u_cs;

  always #5 clk = ~clk;

  spdif_frame_ctrl #(.ENA_DIV(DIV), .LOCK_CNT(LCK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_det_ena(o_det_ena), .i_sym_stb(stb),
    .i_short(i_short), .i_long(i_long), .i_head(i_head), .o_sample(o_sample),
    .o_chan(o_chan), .o_blk_start(o_blk_start), .o_v(o_v), .o_u(o_u), .o_c(o_c),
    .o_par_err(o_par_err), .o_valid(o_valid), .i_ready(ready), .o_overrun(o_overrun),
    .o_sym_err(o_sym_err), .o_locked(o_locked), .o_cs(o_cs), .o_cs_valid(o_cs_valid)
  );

  spdif_frame_ctrl #(.ENA_DIV(1), .LOCK_CNT(LCK)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_det_ena(u_det_ena), .i_sym_stb(1'b0),
    .i_short(1'b0), .i_long(1'b0), .i_head(1'b0), .o_sample(u_sample),
    .o_chan(u_chan), .o_blk_start(u_blk), .o_v(u_v), .o_u(u_u), .o_c(u_c),
    .o_par_err(u_par), .o_valid(u_valid), .i_ready(1'b1), .o_overrun(u_ovr),
    .o_sym_err(u_sym), .o_locked(u_lock), .o_cs(u_cs), .o_cs_valid(u_csv)
  );

  int n_tests = 0, n_fail = 0;
  int n_sym = 0, n_ovr = 0, n_csv = 0;

  always @(posedge clk) begin
    if (o_sym_err)  n_sym <= n_sym + 1;
    if (o_overrun)  n_ovr <= n_ovr + 1;
    if (o_cs_valid) n_csv <= n_csv + 1;
  end

  // Reference model state
  int          m_sym = 0, m_ovr = 0, m_csv = 0, m_lock = 0, m_frame = 0;
  bit          m_have_last = 0, m_last_w = 0, m_pending = 0, m_cs_act = 0;
  logic [39:0] m_cs_acc = '0, m_cs_out = '0;
  logic [39:0] cs_pat = 40'h12_3456_789A;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // cls: 1 short, 2 long, 3 head, 0 none set, 4 two classes set
  task automatic send_iv(input int cls);
    @(negedge clk);
    case (cls)
      1: {i_head, i_long, i_short} = 3'b001;
      2: {i_head, i_long, i_short} = 3'b010;
      3: {i_head, i_long, i_short} = 3'b100;
      4: {i_head, i_long, i_short} = 3'b011;
      default: {i_head, i_long, i_short} = 3'b000;
    endcase
    stb = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    stb = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_pre(input int p);
    send_iv(3);
    case (p)
      0: begin send_iv(1); send_iv(1); send_iv(3); end
      1: begin send_iv(3); send_iv(1); send_iv(1); end
      default: begin send_iv(2); send_iv(1); send_iv(2); end
    endcase
  endtask

  task automatic send_bits(input logic [27:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin send_iv(1); send_iv(1); end
      else send_iv(2);
    end
  endtask

  task automatic model_err();
    m_sym++; m_lock = 0; m_cs_act = 0; m_have_last = 0;
  endtask

  task automatic model_frame(input int p, input logic [27:0] w);
    if (m_have_last && (m_last_w ? (p == 2) : (p == 0))) begin
      m_sym++; m_lock = 0; m_cs_act = 0;
    end
    if (m_pending) m_ovr++;
    m_pending = 1;
    if (^w) m_lock = 0;
    else if (m_lock < LCK) m_lock++;
`ifdef SPDIF_CHSTAT_EN
    if (p != 2) begin
      if (p == 0) begin m_frame = 0; m_cs_act = 1; end
      if (m_cs_act && m_frame < 40) m_cs_acc[m_frame] = w[26];
      if (m_cs_act && m_frame == 39) begin m_cs_out = m_cs_acc; m_csv++; end
      m_frame = (m_frame + 1) % 192;
    end
`endif
    m_have_last = 1; m_last_w = (p == 2);
  endtask

  task automatic check_frame(input int p, input logic [27:0] w);
    check("sample", 64'(o_sample), 64'(w[23:0]));
    check("chan", 64'(o_chan), 64'(p == 2));
    check("blk_start", 64'(o_blk_start), 64'(p == 0));
    check("v", 64'(o_v), 64'(w[24]));
    check("u", 64'(o_u), 64'(w[25]));
    check("c", 64'(o_c), 64'(w[26]));
    check("par_err", 64'(o_par_err), 64'(^w));
    check("valid", 64'(o_valid), 64'(1));
    check("locked", 64'(o_locked), 64'(m_lock == LCK));
    check("sym_err_count", 64'(n_sym), 64'(m_sym));
    check("overrun_count", 64'(n_ovr), 64'(m_ovr));
    check("cs", 64'(o_cs), 64'(m_cs_out));
    check("cs_valid_count", 64'(n_csv), 64'(m_csv));
  endtask

  task automatic consume();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    m_pending = 0;
    check("consume_valid", 64'(o_valid), 64'(0));
  endtask

  task automatic frame(input int p, input logic [27:0] w, input bit take);
    repeat ($urandom_range(0, 2)) send_iv($urandom_range(1, 2));
    send_pre(p);
    send_bits(w, 28);
    model_frame(p, w);
    repeat (2) @(negedge clk);
    check_frame(p, w);
    if (take) consume();
  endtask

  function automatic logic [27:0] rand_word(input bit good);
    logic [27:0] w;
    w = 28'($urandom);
    w[27] = (^w[26:0]) ^ !good;
    return w;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] w;
    int p;

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_sample", 64'(o_sample), 64'(0));
    check("rst_det_ena", 64'(o_det_ena), 64'(0));
    check("rst_locked", 64'(o_locked), 64'(0));
    check("rst_sym_err", 64'(o_sym_err), 64'(0));
    check("rst_cs", 64'(o_cs), 64'(0));
    check("rst_det_ena_div1", 64'(u_det_ena), 64'(1));

    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("det_ena", 64'(o_det_ena), 64'(((k - 1) % DIV) == 0));
      check("det_ena_div1", 64'(u_det_ena), 64'(1));
    end

    // B subframe 0xA5A5A5, V=0 U=1 C=1 P=0, with latency measurement
    w = 28'h6A5A5A5;
    send_iv(1); send_iv(2);
    send_pre(0);
    send_bits(w, 27);
    @(negedge clk); {i_head, i_long, i_short} = 3'b010; stb = 1'b1;
    @(negedge clk); check("latency_evt", 64'(o_valid), 64'(0));
    @(negedge clk); check("latency_commit", 64'(o_valid), 64'(0)); stb = 1'b0;
    @(negedge clk); check("latency_valid", 64'(o_valid), 64'(1));
    model_frame(0, w);
    check_frame(0, w);
    consume();

    // Build lock with alternating legal subframes
    frame(2, rand_word(1), 1);
    for (int i = 0; i < 6; i++) frame((i % 2) ? 2 : 1, rand_word(1), 1);
    frame(1, rand_word(1), 1);
    frame(2, rand_word(0), 1);

    // W after W: sequence error, subframe still decoded
    frame(2, rand_word(1), 1);

    // Head at slot 17 aborts, following 1,1,3 decodes as B
    w = rand_word(1);
    send_pre(1);
    send_bits(w, 13);
    send_iv(3);
    model_err();
    send_iv(1); send_iv(1); send_iv(3);
    w = rand_word(1);
    send_bits(w, 28);
    model_frame(0, w);
    repeat (2) @(negedge clk);
    check_frame(0, w);
    consume();

    // Illegal interval class inside data
    w = rand_word(1);
    send_pre(2);
    send_bits(w, 5);
    send_iv($urandom_range(0, 1) ? 4 : 0);
    model_err();
    repeat (2) @(negedge clk);
    check("bad_class_sym_err", 64'(n_sym), 64'(m_sym));
    frame(1, rand_word(1), 1);

    // Overrun: two subframes without consuming
    frame(2, rand_word(1), 0);
    frame(1, rand_word(1), 1);

    // Reset mid-subframe discards partial data
    w = rand_word(1);
    send_pre(2);
    send_bits(w, 10);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 64'(o_valid), 64'(0));
    check("rst_mid_locked", 64'(o_locked), 64'(0));
    rst_n = 1'b1;
    m_have_last = 0; m_lock = 0; m_pending = 0; m_cs_act = 0; m_frame = 0; m_cs_out = '0;
    frame(2, rand_word(1), 1);

    // Channel-status block: 40 channel-A frames carrying the C pattern
    for (int f = 0; f < 80; f++) begin
      p = (f % 2) ? 2 : ((f == 0) ? 0 : 1);
      w = 28'($urandom);
      if (p != 2) w[26] = cs_pat[f / 2];
      w[27] = ^w[26:0];
      frame(p, w, 1);
    end
`ifdef SPDIF_CHSTAT_EN
    check("cs_final", 64'(o_cs), 64'(cs_pat));
    check("cs_valid_once", 64'(n_csv), 64'(1));
`else
    check("cs_final_off", 64'(o_cs), 64'(0));
    check("cs_valid_off", 64'(n_csv), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
